// File: rtl/cpu_pkg.sv
// Shared CPU constants: register file geometry and writeback source indices.
// Imported by the writeback arbiter and its holding buffers.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_LINK = 2;

  localparam logic [REG_ADDR_W-1:0] REG_RA = 5'd31;

endpackage

// File: rtl/wb_req_buffer.sv
// One-entry writeback holding register with valid/ready handshake.
// Writes to r0 are accepted but never held.
import cpu_pkg::*;

module wb_req_buffer #(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              ready,
  output logic              full,
  output logic [ADDR_W-1:0] out_reg,
  output logic [DATA_W-1:0] out_data
);

  assign ready = !full || grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= 1'b0;
      out_reg  <= '0;
      out_data <= '0;
    end else if (in_valid && ready) begin
      full     <= |in_reg;
      out_reg  <= in_reg;
      out_data <= in_data;
    end else if (grant) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port among ALU, load and link writebacks.
// Define REG_WRITE_ARB_RR_EN for round-robin; default is fixed priority 0>1>2.
import cpu_pkg::*;

module reg_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  output logic                      reg_write,
  output logic [1:0]                grant_id,
  output logic [NUM_REGS-1:0]       pending_mask
);

  logic [NUM_REQ-1:0] buf_full;
  logic [NUM_REQ-1:0] grant;
  logic [ADDR_W-1:0]  buf_reg  [NUM_REQ];
  logic [DATA_W-1:0]  buf_data [NUM_REQ];
  logic               any_full;
  logic [1:0]         win;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_buf
    wb_req_buffer #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .in_valid(req_valid[i]),
      .in_reg  (req_reg[i*ADDR_W +: ADDR_W]),
      .in_data (req_data[i*DATA_W +: DATA_W]),
      .grant   (grant[i]),
      .ready   (req_ready[i]),
      .full    (buf_full[i]),
      .out_reg (buf_reg[i]),
      .out_data(buf_data[i])
    );
  end

  assign any_full = |buf_full;

`ifdef REG_WRITE_ARB_RR_EN
  logic [1:0] rr_ptr;

  // Search starts at the pointer and wraps at NUM_REQ.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && buf_full[idx]) begin
        win   = 2'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (any_full) begin
      rr_ptr <= (int'(win) == NUM_REQ - 1) ? 2'd0 : win + 2'd1;
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (buf_full[i]) win = 2'(i);
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (any_full) grant[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      grant_id   <= '0;
    end else begin
      reg_write <= any_full;
      if (any_full) begin
        write_reg  <= buf_reg[win];
        write_data <= buf_data[win];
        grant_id   <= win;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (buf_full[i]) pending_mask[buf_reg[i]] = 1'b1;
    end
    if (reg_write) pending_mask[write_reg] = 1'b1;
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter.
// Expectations follow REG_WRITE_ARB_RR_EN when it is defined.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [1:0]  grant_id;
  logic [31:0] pending_mask;

  int cmp = 0;
  int err = 0;

  reg_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_reg     (req_reg),
    .req_data    (req_data),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .reg_write   (reg_write),
    .grant_id    (grant_id),
    .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic v,
                         input logic [4:0] r, input logic [31:0] d);
    req_valid[i]       = v;
    req_reg[i*5 +: 5]  = r;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = '0;
    req_reg = '0;
    req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp++;
    if (reg_write !== 1'b0) begin
      err++; $display("FAIL rst_we: got %b want 0", reg_write);
    end
    cmp++;
    if (write_reg !== 5'd0 || write_data !== 32'd0 || grant_id !== 2'd0) begin
      err++;
      $display("FAIL rst_out: got %h/%h/%h want 0/0/0",
               write_reg, write_data, grant_id);
    end
    cmp++;
    if (pending_mask !== 32'd0) begin
      err++; $display("FAIL rst_mask: got %h want 0", pending_mask);
    end
    cmp++;
    if (req_ready !== 3'b111) begin
      err++; $display("FAIL rst_ready: got %b want 111", req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single;
    step();
    set_req(0, 1'b1, 5'd8, 32'h0000_1234);
    step();
    set_req(0, 1'b0, 5'd0, 32'd0);
    cmp++;
    if (reg_write !== 1'b0 || pending_mask !== 32'h100) begin
      err++;
      $display("FAIL single_acc: we=%b mask=%h want 0/00000100",
               reg_write, pending_mask);
    end
    step();
    cmp++;
    if (reg_write !== 1'b1 || write_reg !== 5'd8 ||
        write_data !== 32'h1234 || grant_id !== 2'd0) begin
      err++;
      $display("FAIL single_grant: we=%b reg=%0d data=%h id=%0d want 1/8/1234/0",
               reg_write, write_reg, write_data, grant_id);
    end
    cmp++;
    if (pending_mask !== 32'h100) begin
      err++; $display("FAIL single_mask1: got %h want 00000100", pending_mask);
    end
    step();
    cmp++;
    if (reg_write !== 1'b0 || pending_mask !== 32'd0 || write_reg !== 5'd8) begin
      err++;
      $display("FAIL single_done: we=%b mask=%h reg=%0d want 0/0/8",
               reg_write, pending_mask, write_reg);
    end
  endtask

  task automatic test_all_three;
    logic [1:0]  exp_id [3];
    logic [4:0]  regs   [3];
    logic [31:0] dats   [3];
    regs[0] = 5'd8;  regs[1] = 5'd9;  regs[2] = 5'd31;
    dats[0] = 32'hA; dats[1] = 32'hB; dats[2] = 32'hC;
`ifdef REG_WRITE_ARB_RR_EN
    exp_id[0] = 2'd1; exp_id[1] = 2'd2; exp_id[2] = 2'd0;
`else
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2;
`endif
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, regs[i], dats[i]);
    step();
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 5'd0, 32'd0);
    cmp++;
    if (pending_mask !== 32'h8000_0300 || reg_write !== 1'b0) begin
      err++;
      $display("FAIL all3_acc: mask=%h we=%b want 80000300/0",
               pending_mask, reg_write);
    end
    for (int g = 0; g < 3; g++) begin
      step();
      cmp++;
      if (reg_write !== 1'b1 || grant_id !== exp_id[g] ||
          write_reg !== regs[exp_id[g]] || write_data !== dats[exp_id[g]]) begin
        err++;
        $display("FAIL all3_g%0d: we=%b id=%0d reg=%0d data=%h want id %0d",
                 g, reg_write, grant_id, write_reg, write_data, exp_id[g]);
      end
    end
    step();
    cmp++;
    if (reg_write !== 1'b0 || pending_mask !== 32'd0) begin
      err++;
      $display("FAIL all3_done: we=%b mask=%h want 0/0", reg_write, pending_mask);
    end
  endtask

  task automatic test_r0;
    set_req(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    for (int c = 0; c < 3; c++) begin
      step();
      cmp++;
      if (req_ready[0] !== 1'b1 || reg_write !== 1'b0 || pending_mask !== 32'd0) begin
        err++;
        $display("FAIL r0_c%0d: rdy=%b we=%b mask=%h want 1/0/0",
                 c, req_ready[0], reg_write, pending_mask);
      end
    end
    set_req(0, 1'b0, 5'd0, 32'd0);
    step();
    cmp++;
    if (reg_write !== 1'b0) begin
      err++; $display("FAIL r0_after: we=%b want 0", reg_write);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      set_req(1, 1'b1, 5'(5 + i), 32'h100 + i);
      cmp++;
      if (req_ready[1] !== 1'b1) begin
        err++; $display("FAIL b2b_rdy%0d: got %b want 1", i, req_ready[1]);
      end
      step();
      if (i >= 1) begin
        cmp++;
        if (reg_write !== 1'b1 || grant_id !== 2'd1 ||
            write_reg !== 5'(4 + i) || write_data !== 32'h100 + i - 1) begin
          err++;
          $display("FAIL b2b_w%0d: we=%b id=%0d reg=%0d data=%h want 1/1/%0d/%h",
                   i, reg_write, grant_id, write_reg, write_data,
                   4 + i, 32'h100 + i - 1);
        end
      end
    end
    set_req(1, 1'b0, 5'd0, 32'd0);
    step();
    cmp++;
    if (reg_write !== 1'b1 || write_reg !== 5'd10 || write_data !== 32'h105) begin
      err++;
      $display("FAIL b2b_last: we=%b reg=%0d data=%h want 1/10/105",
               reg_write, write_reg, write_data);
    end
    step();
    cmp++;
    if (reg_write !== 1'b0) begin
      err++; $display("FAIL b2b_done: we=%b want 0", reg_write);
    end
  endtask

  task automatic test_starvation;
    set_req(0, 1'b1, 5'd3, 32'h33);
    set_req(2, 1'b1, 5'd31, 32'h0040_0008);
    step();
    set_req(2, 1'b0, 5'd0, 32'd0);
`ifdef REG_WRITE_ARB_RR_EN
    begin
      int hits;
      hits = 0;
      for (int c = 0; c < 2; c++) begin
        step();
        if (reg_write && grant_id == 2'd2 && write_data == 32'h0040_0008) hits++;
      end
      cmp++;
      if (hits !== 1) begin
        err++; $display("FAIL rr_link: got %0d link grants want 1", hits);
      end
    end
    set_req(0, 1'b0, 5'd0, 32'd0);
    repeat (3) step();
`else
    for (int c = 0; c < 6; c++) begin
      step();
      cmp++;
      if (reg_write !== 1'b1 || grant_id !== 2'd0 || req_ready[2] !== 1'b0) begin
        err++;
        $display("FAIL starve_c%0d: we=%b id=%0d rdy2=%b want 1/0/0",
                 c, reg_write, grant_id, req_ready[2]);
      end
    end
    set_req(0, 1'b0, 5'd0, 32'd0);
    step();
    step();
    cmp++;
    if (reg_write !== 1'b1 || grant_id !== 2'd2 ||
        write_reg !== 5'd31 || write_data !== 32'h0040_0008) begin
      err++;
      $display("FAIL starve_link: we=%b id=%0d reg=%0d data=%h want 1/2/31/00400008",
               reg_write, grant_id, write_reg, write_data);
    end
    step();
`endif
    cmp++;
    if (reg_write !== 1'b0 || pending_mask !== 32'd0) begin
      err++;
      $display("FAIL starve_done: we=%b mask=%h want 0/0", reg_write, pending_mask);
    end
  endtask

  task automatic test_reset_mid;
    set_req(0, 1'b1, 5'd8, 32'hA);
    set_req(1, 1'b1, 5'd9, 32'hB);
    set_req(2, 1'b1, 5'd31, 32'hC);
    step();
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 5'd0, 32'd0);
    step();
    cmp++;
    if (reg_write !== 1'b1) begin
      err++; $display("FAIL mid_pre: we=%b want 1", reg_write);
    end
    #3;
    reset = 1'b1;
    #1;
    cmp++;
    if (reg_write !== 1'b0 || pending_mask !== 32'd0 || req_ready !== 3'b111) begin
      err++;
      $display("FAIL mid_async: we=%b mask=%h rdy=%b want 0/0/111",
               reg_write, pending_mask, req_ready);
    end
    #2;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      cmp++;
      if (reg_write !== 1'b0 || pending_mask !== 32'd0) begin
        err++;
        $display("FAIL mid_stale%0d: we=%b mask=%h want 0/0",
                 c, reg_write, pending_mask);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_r0();
    test_back_to_back();
    test_starvation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the single register-file write port (`write_reg`, `write_data`, `reg_write`) between several writeback sources: ALU result, memory load return, and link write (r31 on JAL/JALR). Each source has a one-entry holding buffer with valid/ready handshake. A per-cycle arbiter picks one buffered entry and drives a registered write command into the register file. A 32-bit pending mask is exported to hazard/stall logic so a read of a not-yet-written register can be held off.

## Interface
- `NUM_REQ`, default 3: number of writeback requesters. Index 0 = ALU, 1 = load, 2 = link.
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: register data width.
- `clk` in 1: single clock. All state updates on posedge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `req_valid` in NUM_REQ: per-requester write request.
- `req_ready` out NUM_REQ: per-requester buffer can accept.
- `req_reg` in NUM_REQ*ADDR_W: packed destination registers. Requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_data` in NUM_REQ*DATA_W: packed write data, packed the same way.
- `write_reg` out ADDR_W: to register file.
- `write_data` out DATA_W: to register file.
- `reg_write` out 1: register-file write enable.
- `grant_id` out 2: index of the requester behind the current `reg_write`.
- `pending_mask` out 32: bit r is set while any buffer or the output stage holds a write to register r.

## Operation
- Handshake: a transfer happens at a posedge where `req_valid[i] & req_ready[i]`. `req_ready[i]` = buffer i empty OR buffer i granted this cycle (same-cycle refill).
- Register r0: a transfer with `req_reg` = 0 is accepted and discarded. The buffer stays empty and no write is issued.
- Arbitration is combinational over full buffers. The winner is moved into the output stage at the next posedge; its buffer clears or refills.
- Output stage: `reg_write` = 1 for exactly one cycle per grant, with `write_reg`/`write_data`/`grant_id` held stable for that cycle. With no full buffer, `reg_write` = 0 and other outputs hold their last value.
- Same-register conflict between buffers: the arbiter order decides which write lands first, and both writes land. Issue order is the program order the producers must respect; the arbiter does not reorder within one requester.
- `pending_mask` = OR of one-hot(`req_reg`) of full buffers, plus one-hot(`write_reg`) while `reg_write` = 1. Bit 0 is always 0.
- Reset values: all buffers empty, `req_ready` all 1, `reg_write` 0, `write_reg` 0, `write_data` 0, `grant_id` 0, `pending_mask` 0. The round-robin pointer is 0 when that option is compiled in.
- Reset mid-operation: buffered and in-flight writes are dropped, with no partial write. Because reset is asynchronous, `reg_write` falls at reset assertion.

## Timing
- Accept at edge N. If uncontested, the entry is granted at edge N+1 (`reg_write` high during cycle N+1). The register file captures it at edge N+2.
- Throughput: one write per cycle sustained. A requester streaming alone with constant valid sees `req_ready` held at 1.
- Worst-case wait under fixed priority is unbounded for index 2. Under round-robin it is NUM_REQ-1 grants.
- No combinational path from `req_valid` to `reg_write`. `req_ready` depends only on state and the current grant.

## Configuration
- `REG_WRITE_ARB_RR_EN` defined: round-robin arbitration. The pointer advances to (winner+1) mod NUM_REQ after each grant, and the search starts at the pointer.
- Not defined: fixed priority, index 0 > 1 > 2, with no pointer register.
- Port list is identical in both builds.

## Structure
- Shared package `cpu_pkg`: `REG_ADDR_W`=5, `REG_DATA_W`=32, `NUM_REGS`=32, the requester index constants `WB_ALU`=0, `WB_LOAD`=1, `WB_LINK`=2, and the link register constant `REG_RA`=31.
- One sub-module, `wb_req_buffer`: the one-entry holding register with valid/ready, instantiated NUM_REQ times. Arbiter, output stage and mask logic live in the top module.

## Test plan
- Single ALU write r8=0x0000_1234, accepted at edge N → `reg_write` high cycle N+1 only, `write_reg`=8, `grant_id`=0. `pending_mask`=0x100 from N to N+1, then 0.
- All three requesters write at one edge (r8=0xA, r9=0xB, r31=0xC). Fixed build → grants 0,1,2 on three consecutive cycles. RR build with pointer at 1 → grants 1,2,0.
- Write to r0 with data 0xFFFF_FFFF → `req_ready` stays 1, `reg_write` never asserts, `pending_mask` stays 0.
- Load requester back-to-back valid with ALU idle → one grant per cycle, `req_ready[1]` never drops.
- Fixed build: ALU valid every cycle while link holds r31=0x0040_0008 → link never granted and `req_ready[2]`=0 throughout. RR build: link granted within 2 cycles.
- Assert `reset` asynchronously mid-cycle with all buffers full and `reg_write`=1 → `reg_write`, `pending_mask` go 0 immediately. After release, no stale write is issued.
